// File: rtl/wand_bus_pkg.sv
// Shared types and constants for the wired-AND
// arbitrating transmitter.
package wand_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_BIT_CYCLES = 4;

endpackage

// File: rtl/wand_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while run
// is high and flags the last cycle of each period.
module wand_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int CW =
    (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last  = (r_cnt == LAST);
  assign bit_end = run && w_last;

  // Cycle counter, wraps per bit, held at zero when idle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wand_arb_tx.sv
// Open-drain transmitter with bitwise arbitration on a
// wired-AND line; withdraws on a dominant-over-recessive read.
module wand_arb_tx
  import wand_bus_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              line_in,
  output logic              drive_low,
  output logic              busy,
  output logic              done,
  output logic              lost
);

  localparam int BW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_done;
  logic              r_lost;

  logic w_run;
  logic w_bit_end;
  logic w_tx_bit;
  logic w_accept;
  logic w_lose;
  logic w_shift;
  logic w_fin;

  assign w_run    = (r_state != IDLE);
  assign w_accept = (r_state == IDLE) && start && line_in;
  // Only a recessive bit can be overridden by another node
  assign w_lose   = w_bit_end && w_tx_bit && !line_in;

  assign done = r_done;
  assign lost = r_lost;

  wand_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (w_run),
    .bit_end(w_bit_end)
  );

  // Level this node is presenting for the current bit
  always_comb begin
    w_tx_bit = STOP_LEVEL;
    case (r_state)
      START:   w_tx_bit = START_LEVEL;
      DATA:    w_tx_bit = r_shift[DATA_W-1];
      STOP:    w_tx_bit = STOP_LEVEL;
      default: w_tx_bit = STOP_LEVEL;
    endcase
  end

  // Frame sequencing and open-drain outputs
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_fin       = 1'b0;
    busy        = w_run;
    drive_low   = w_run && !w_tx_bit;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = START;
      end
      START: begin
        if (w_lose) begin
          w_state_nxt = IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_lose) begin
          w_state_nxt = IDLE;
        end else if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_lose) begin
          w_state_nxt = IDLE;
        end else if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload shifter and data-bit counter; hold while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= data;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift <= r_shift << 1;
      if (r_bit_cnt == LAST_BIT) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  // One-cycle completion and withdrawal pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_done <= w_fin;
      r_lost <= w_lose;
    end
  end

endmodule

// File: tb/tb_wand_arb_tx.sv
// Randomized scoreboard bench for wand_arb_tx with a
// competing bench-side transmitter on the wired-AND line.
module tb_wand_arb_tx;

  localparam int BC = 4;
  localparam int NB = 10;

  typedef struct packed {
    int   cyc;
    logic dl;
    logic bsy;
    logic dn;
    logic ls;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       line_in;
  logic       drive_low;
  logic       busy;
  logic       done;
  logic       lost;
  logic       other_low;
  logic       ext_low;

  int cyc    = 0;
  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  rec_t exq[$];
  rec_t mtr[$];
  logic mob[$];
  logic oth_q[$];
  int   oth_base = 0;

  assign line_in = !(drive_low | other_low | ext_low);

  wand_arb_tx #(
    .DATA_W    (8),
    .BIT_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .line_in  (line_in),
    .drive_low(drive_low),
    .busy     (busy),
    .done     (done),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
    if (cyc >= oth_base && (cyc - oth_base) < oth_q.size())
      other_low = oth_q[cyc - oth_base];
    else
      other_low = 1'b0;
  endtask

  // Bit-level view of a frame: per cycle expectations for the
  // DUT and the drive schedule of the competing node.
  task automatic model(input logic [7:0] dd,
                       input logic [7:0] od,
                       input bit ho);
    logic [9:0] db;
    logic [9:0] ob;
    bit   dact;
    bit   oact;
    logic dl;
    logic ol;
    logic ln;
    rec_t r;
    db = {1'b0, dd, 1'b1};
    ob = {1'b0, od, 1'b1};
    mtr.delete();
    mob.delete();
    dact = 1'b1;
    oact = ho;
    for (int k = 0; k < NB; k++) begin
      dl = dact && !db[NB-1-k];
      ol = oact && !ob[NB-1-k];
      ln = !(dl | ol);
      for (int j = 0; j < BC; j++) begin
        if (dact) begin
          r.cyc = 0; r.dl = dl; r.bsy = 1'b1;
          r.dn = 1'b0; r.ls = 1'b0;
          mtr.push_back(r);
        end
        mob.push_back(ol);
      end
      if (dact && db[NB-1-k] && !ln) begin
        dact = 1'b0;
        r.cyc = 0; r.dl = 1'b0; r.bsy = 1'b0;
        r.dn = 1'b0; r.ls = 1'b1;
        mtr.push_back(r);
      end
      if (oact && ob[NB-1-k] && !ln) oact = 1'b0;
    end
    if (dact) begin
      r.cyc = 0; r.dl = 1'b0; r.bsy = 1'b0;
      r.dn = 1'b1; r.ls = 1'b0;
      mtr.push_back(r);
    end
  endtask

  task automatic send(input logic [7:0] dd,
                      input logic [7:0] od,
                      input bit ho,
                      input int cut,
                      output int len,
                      output int oend);
    int   c;
    rec_t r;
    c = cyc;
    model(dd, od, ho);
    start = 1'b1;
    data  = dd;
    for (int i = 0; i < mtr.size(); i++) begin
      if (cut < 0 || i < cut) begin
        r = mtr[i];
        r.cyc = c + 1 + i;
        exq.push_back(r);
      end
    end
    oth_q    = mob;
    oth_base = c + 1;
    len  = mtr.size();
    oend = c + mob.size();
    step();
    start = 1'b0;
  endtask

  task automatic wait_to(input int tgt, input bit noise);
    while (cyc < tgt) begin
      if (noise && $urandom_range(0, 5) == 0) begin
        start = 1'b1;
        data  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic frame(input logic [7:0] dd,
                       input logic [7:0] od,
                       input bit ho,
                       input bit noise);
    int c;
    int len;
    int oend;
    c = cyc;
    send(dd, od, ho, -1, len, oend);
    wait_to(c + len, noise);
    if (oend + 1 > cyc) wait_to(oend + 1, 1'b0);
  endtask

  // Scoreboard monitor: recorded cycles are compared against the
  // queued expectation; any other cycle must be fully idle.
  always @(negedge clk) begin
    rec_t r;
    if (chk_en) begin
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL missed_sample cyc=%0d", exq[0].cyc);
        void'(exq.pop_front());
      end
      if (exq.size() > 0 && exq[0].cyc == cyc) begin
        r = exq.pop_front();
        checks++;
        if ({drive_low, busy, done, lost} !==
            {r.dl, r.bsy, r.dn, r.ls}) begin
          fails++;
          $display("FAIL frame_out cyc=%0d dl/busy/done/lost got=%b%b%b%b exp=%b%b%b%b",
                   cyc, drive_low, busy, done, lost,
                   r.dl, r.bsy, r.dn, r.ls);
        end
      end else begin
        checks++;
        if ({drive_low, busy, done, lost} !== 4'b0000) begin
          fails++;
          $display("FAIL idle_out cyc=%0d dl/busy/done/lost got=%b%b%b%b exp=0000",
                   cyc, drive_low, busy, done, lost);
        end
      end
    end
  end

  initial begin
    int c0;
    int len;
    int oend;
    int t;
    rst       = 1'b1;
    start     = 1'b0;
    data      = 8'h00;
    ext_low   = 1'b0;
    other_low = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();

    // solo frame, then loss, then win
    frame(8'hA5, 8'h00, 1'b0, 1'b0);
    frame(8'hA5, 8'hA4, 1'b1, 1'b0);
    frame(8'h5A, 8'hDA, 1'b1, 1'b0);

    // start while the line is held low is dropped
    ext_low = 1'b1;
    start   = 1'b1;
    data    = 8'h3C;
    step();
    start   = 1'b0;
    ext_low = 1'b0;
    step();

    // starts and data changes during a frame are ignored
    c0 = cyc;
    send(8'hA5, 8'h00, 1'b0, -1, len, oend);
    while (cyc < c0 + len) begin
      if (cyc - c0 == 5 || cyc - c0 == 20) begin
        start = 1'b1;
        data  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (cyc - c0 == 12) data = 8'h00;
      step();
    end
    start = 1'b0;
    step();

    // reset sampled in cycle 15 of a frame
    c0 = cyc;
    send(8'h96, 8'h00, 1'b0, 15, len, oend);
    wait_to(c0 + 15, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    frame(8'h69, 8'h00, 1'b0, 1'b0);

    // back-to-back frames
    frame(8'h3C, 8'h00, 1'b0, 1'b0);
    frame(8'hC3, 8'h00, 1'b0, 1'b0);

    // randomized frames with optional competitor
    for (int n = 0; n < 30; n++) begin
      t = $urandom_range(0, 2);
      for (int g = 0; g < t; g++) step();
      frame(8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'b1);
    end

    t = 0;
    while (exq.size() > 0 && t < 100) begin
      step();
      t++;
    end
    if (exq.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain left=%0d exp=0", exq.size());
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
